// File: rtl/dota_pkg.sv
// -----------------------------------------------------------------------------
// dota_pkg
//   Shared types and default widths for the OTA sample sequencer.
//   - state_t      : sequencer FSM state (2-bit encoding)
//   - *_W_DEF      : default widths for settle length, sample count and the
//                    statistics counters
// -----------------------------------------------------------------------------
package dota_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int SETTLE_W_DEF = 8;
    localparam int NSAMP_W_DEF  = 4;
    localparam int STAT_W_DEF   = 16;

endpackage

// File: rtl/dota_sample_ctrl_if.sv
// -----------------------------------------------------------------------------
// dota_sample_ctrl_if
//   Result hand-off port of the OTA sample sequencer.
//   Signals:
//     res_valid  producer -> consumer  decision available
//     res_ready  consumer -> producer  consumer accepts decision
//     res_bit    producer -> consumer  majority decision
//     res_ones   producer -> consumer  number of 1 samples behind the decision
//   Modports: master (sequencer side), slave (consumer side).
//
//   Handshake: a transfer happens on every rising clk edge where res_valid and
//   res_ready are both high. Once res_valid is raised, res_valid, res_bit and
//   res_ones hold stable until that transfer; res_valid never depends
//   combinationally on res_ready, and res_ready may be held high in advance.
// -----------------------------------------------------------------------------
interface dota_sample_ctrl_if
    import dota_pkg::*;
#(
    parameter int NSAMP_W = NSAMP_W_DEF
) ();

    logic               res_valid;
    logic               res_ready;
    logic               res_bit;
    logic [NSAMP_W:0]   res_ones;

    modport master (
        output res_valid,
        output res_bit,
        output res_ones,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_bit,
        input  res_ones,
        output res_ready
    );

endinterface

// File: rtl/dota_sample_ctrl_sync2.sv
// -----------------------------------------------------------------------------
// dota_sync2
//   Two-flop synchronizer for a single asynchronous bit.
//   Ports:
//     clk    in   destination clock
//     rst_n  in   asynchronous active-low reset, both flops clear to 0
//     d_i    in   asynchronous input
//     q_o    out  synchronized output (second flop)
// -----------------------------------------------------------------------------
module dota_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/dota_sample_ctrl.sv
// -----------------------------------------------------------------------------
// dota_sample_ctrl
//   Sequencer for the digital-gate OTA/comparator. Powers the OTA, waits a
//   programmable settle time, takes N synchronized samples of its output,
//   majority-votes them and hands the decision off on a valid/ready port.
//
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     ena                block enable; low aborts to IDLE on the next edge
//     start              1-cycle pulse, starts a conversion from IDLE
//     cfg_cont           continuous mode (latched at start)
//     cfg_settle         settle cycles minus one (latched at start)
//     cfg_nsamp          sample count minus one (latched at start)
//     cmp_in             raw, asynchronous OTA output
//     ota_en             OTA enable / bias gate
//     busy               high in every state except IDLE
//     stat_conv, stat_hi delivered / delivered-high decision counters
//     dbg_state_o        current FSM state
//     res_if             result port (master modport of dota_sample_ctrl_if)
//
//   Optional feature macro: DOTA_STATS_EN
//     defined   -> saturating stat_conv/stat_hi counters, cleared only by rst_n
//     undefined -> stat_conv/stat_hi tied to 0, no counter flops
// -----------------------------------------------------------------------------
module dota_sample_ctrl
    import dota_pkg::*;
#(
    parameter int SETTLE_W = SETTLE_W_DEF,
    parameter int NSAMP_W  = NSAMP_W_DEF,
    parameter int STAT_W   = STAT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    input  logic                cfg_cont,
    input  logic [SETTLE_W-1:0] cfg_settle,
    input  logic [NSAMP_W-1:0]  cfg_nsamp,
    input  logic                cmp_in,
    output logic                ota_en,
    output logic                busy,
    output logic [STAT_W-1:0]   stat_conv,
    output logic [STAT_W-1:0]   stat_hi,
    output state_t              dbg_state_o,
    dota_sample_ctrl_if.master  res_if
);

    // One down-counter serves both the settle and the sample phase.
    localparam int CNT_W  = (SETTLE_W > NSAMP_W) ? SETTLE_W : NSAMP_W;
    localparam int ONES_W = NSAMP_W + 1;

    logic                cmp_sync;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [ONES_W-1:0]   ones_q,      ones_d;
    logic [NSAMP_W-1:0]  nsamp_q,     nsamp_d;
    logic                cont_q,      cont_d;
    logic                res_bit_q,   res_bit_d;
    logic [ONES_W-1:0]   res_ones_q,  res_ones_d;
    logic                res_valid_q, res_valid_d;
    logic                ota_en_q,    ota_en_d;

    logic [ONES_W-1:0]   ones_acc;
    logic [ONES_W-1:0]   n_full;

    dota_sync2 u_cmp_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_in),
        .q_o   (cmp_sync)
    );

    // Running count including this cycle's sample, and N = nsamp+1.
    assign ones_acc = ones_q + {{NSAMP_W{1'b0}}, cmp_sync};
    assign n_full   = {1'b0, nsamp_q} + ONES_W'(1);

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        nsamp_d    = nsamp_q;
        cont_d     = cont_q;
        res_bit_d  = res_bit_q;
        res_ones_d = res_ones_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    nsamp_d = cfg_nsamp;
                    cont_d  = cfg_cont;
                    cnt_d   = CNT_W'(cfg_settle);
                    ones_d  = '0;
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(nsamp_q);
                    ones_d  = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            SAMPLE: begin
                ones_d = ones_acc;
                if (cnt_q == '0) begin
                    // Strict majority: 2*ones > N, so a tie resolves to 0.
                    res_ones_d = ones_acc;
                    res_bit_d  = ({ones_acc, 1'b0} > {1'b0, n_full});
                    state_d    = REPORT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            REPORT: begin
                if (res_if.res_ready) begin
                    if (cont_q) begin
                        // Continuous mode re-samples without re-settling.
                        cnt_d   = CNT_W'(nsamp_q);
                        ones_d  = '0;
                        state_d = SAMPLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Disable has priority over everything, including a same-cycle start.
        if (!ena) begin
            state_d = IDLE;
            cnt_d   = '0;
            ones_d  = '0;
        end

        // Outputs are registered from the next state so they are glitch-free.
        ota_en_d    = (state_d != IDLE);
        res_valid_d = (state_d == REPORT);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ones_q      <= '0;
            nsamp_q     <= '0;
            cont_q      <= 1'b0;
            res_bit_q   <= 1'b0;
            res_ones_q  <= '0;
            res_valid_q <= 1'b0;
            ota_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            nsamp_q     <= nsamp_d;
            cont_q      <= cont_d;
            res_bit_q   <= res_bit_d;
            res_ones_q  <= res_ones_d;
            res_valid_q <= res_valid_d;
            ota_en_q    <= ota_en_d;
        end
    end

    assign ota_en           = ota_en_q;
    assign busy             = (state_q != IDLE);
    assign dbg_state_o      = state_q;
    assign res_if.res_valid = res_valid_q;
    assign res_if.res_bit   = res_bit_q;
    assign res_if.res_ones  = res_ones_q;

    // -------------------------------------------------------------------------
    // Optional delivery statistics
    // -------------------------------------------------------------------------
`ifdef DOTA_STATS_EN
    logic              hs;
    logic [STAT_W-1:0] conv_q;
    logic [STAT_W-1:0] hi_q;

    assign hs = res_valid_q & res_if.res_ready;

    // Counters saturate at all-ones and ignore ena; only rst_n clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_q <= '0;
            hi_q   <= '0;
        end else if (hs) begin
            if (conv_q != '1) begin
                conv_q <= conv_q + STAT_W'(1);
            end
            if (res_bit_q && (hi_q != '1)) begin
                hi_q <= hi_q + STAT_W'(1);
            end
        end
    end

    assign stat_conv = conv_q;
    assign stat_hi   = hi_q;
`else
    assign stat_conv = '0;
    assign stat_hi   = '0;
`endif

endmodule

// File: tb/tb_dota_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dota_sample_ctrl
//   Self-checking bench for dota_sample_ctrl. Expected decisions are queued
//   when a conversion is started and compared when the result is handed off.
// -----------------------------------------------------------------------------
module tb_dota_sample_ctrl;
    import dota_pkg::*;

    localparam int SETTLE_W = 8;
    localparam int NSAMP_W  = 4;
    localparam int STAT_W   = 16;
    localparam int EXP_W    = NSAMP_W + 2;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                ena;
    logic                start;
    logic                cfg_cont;
    logic [SETTLE_W-1:0] cfg_settle;
    logic [NSAMP_W-1:0]  cfg_nsamp;
    logic                cmp_in;
    logic                ota_en;
    logic                busy;
    logic [STAT_W-1:0]   stat_conv;
    logic [STAT_W-1:0]   stat_hi;
    state_t              dbg_state;

    dota_sample_ctrl_if #(.NSAMP_W(NSAMP_W)) res_if ();

    dota_sample_ctrl #(
        .SETTLE_W (SETTLE_W),
        .NSAMP_W  (NSAMP_W),
        .STAT_W   (STAT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .start       (start),
        .cfg_cont    (cfg_cont),
        .cfg_settle  (cfg_settle),
        .cfg_nsamp   (cfg_nsamp),
        .cmp_in      (cmp_in),
        .ota_en      (ota_en),
        .busy        (busy),
        .stat_conv   (stat_conv),
        .stat_hi     (stat_hi),
        .dbg_state_o (dbg_state),
        .res_if      (res_if)
    );

    // ---------------------------------------------------------------- scoreboard
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_exp;
    int exp_conv = 0;
    int exp_hi   = 0;

    // A transfer happens at the next rising edge when both are high now.
    always @(negedge clk) begin
        if (rst_n && res_if.res_valid && res_if.res_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got bit=%0b ones=%0d, required no result",
                         res_if.res_bit, res_if.res_ones);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({res_if.res_bit, res_if.res_ones} !== mon_exp) begin
                    errors++;
                    $display("FAIL result: got bit=%0b ones=%0d, required bit=%0b ones=%0d",
                             res_if.res_bit, res_if.res_ones,
                             mon_exp[EXP_W-1], mon_exp[EXP_W-2:0]);
                end
                exp_conv++;
                if (mon_exp[EXP_W-1]) exp_hi++;
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input logic b, input int ones);
        logic [EXP_W-2:0] o;
        o = (EXP_W-1)'(ones);
        exp_q.push_back({b, o});
    endtask

    // Pulses start and counts edges (the sampling edge is edge 1) until
    // res_valid is seen; returns -1 if the budget runs out.
    task automatic start_and_wait(output int lat);
        int n;
        n     = 0;
        start = 1'b1;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end while (!res_if.res_valid && n < 600);
        lat = res_if.res_valid ? n : -1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n            = 1'b0;
        ena              = 1'b1;
        start            = 1'b0;
        cfg_cont         = 1'b0;
        cfg_settle       = '0;
        cfg_nsamp        = '0;
        cmp_in           = 1'b0;
        res_if.res_ready = 1'b1;
        step(3);
        checks++;
        if ({ota_en, busy, res_if.res_valid, res_if.res_bit} !== 4'b0000 || res_if.res_ones !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ota_en=%0b busy=%0b valid=%0b bit=%0b ones=%0d, required all 0",
                     ota_en, busy, res_if.res_valid, res_if.res_bit, res_if.res_ones);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++;
            $display("FAIL reset_state: got %0d, required %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        step(2);
        checks++;
        if (stat_conv !== '0 || stat_hi !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_stats: got conv=%0d hi=%0d busy=%0b, required 0 0 0",
                     stat_conv, stat_hi, busy);
        end
    endtask

    task automatic test_basic();
        int lat;
        cmp_in = 1'b1; cfg_settle = 8'd3; cfg_nsamp = 4'd4; cfg_cont = 1'b0;
        res_if.res_ready = 1'b1;
        step(3);
        push_exp(1'b1, 5);
        start_and_wait(lat);
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL basic_latency: got %0d, required 10", lat);
        end
        checks++;
        if (ota_en !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_ota_on: got ota_en=%0b busy=%0b, required 1 1", ota_en, busy);
        end
        step(1);
        checks++;
        if (ota_en !== 1'b0 || busy !== 1'b0 || res_if.res_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL basic_return_idle: got ota_en=%0b busy=%0b valid=%0b state=%0d, required 0 0 0 0",
                     ota_en, busy, res_if.res_valid, dbg_state);
        end
    endtask

    task automatic test_tie();
        int lat;
        cfg_settle = 8'd2; cfg_nsamp = 4'd3; cfg_cont = 1'b0;
        res_if.res_ready = 1'b1;
        push_exp(1'b0, 2);
        lat = 0;
        fork
            begin
                repeat (20) begin
                    @(posedge clk);
                    #2;
                    cmp_in = ~cmp_in;
                end
            end
            begin
                start_and_wait(lat);
            end
        join
        step(1);
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL tie_latency: got %0d, required 8", lat);
        end
        checks++;
        if (res_if.res_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL tie_idle: got valid=%0b state=%0d, required 0 0", res_if.res_valid, dbg_state);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        cmp_in = 1'b1; cfg_settle = 8'd0; cfg_nsamp = 4'd2; cfg_cont = 1'b0;
        res_if.res_ready = 1'b0;
        step(3);
        push_exp(1'b1, 3);
        start_and_wait(lat);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL bp_latency: got %0d, required 5", lat);
        end
        cmp_in = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (res_if.res_valid !== 1'b1 || res_if.res_bit !== 1'b1 || res_if.res_ones !== 5'd3) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%0b bit=%0b ones=%0d, required 1 1 3",
                         i, res_if.res_valid, res_if.res_bit, res_if.res_ones);
            end
        end
        res_if.res_ready = 1'b1;
        step(1);
        checks++;
        if (res_if.res_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL bp_release: got valid=%0b state=%0d, required 0 0", res_if.res_valid, dbg_state);
        end
    endtask

    task automatic test_continuous();
        int lat;
        cmp_in = 1'b1; cfg_settle = 8'd5; cfg_nsamp = 4'd0; cfg_cont = 1'b1;
        res_if.res_ready = 1'b1;
        step(3);
        repeat (3) push_exp(1'b1, 1);
        start_and_wait(lat);
        cfg_cont = 1'b0;   // must not end continuous mode
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL cont_latency: got %0d, required 8", lat);
        end
        for (int k = 1; k <= 6; k++) begin
            step(1);
            checks++;
            if (res_if.res_valid !== ((k % 2) == 0) || ota_en !== 1'b1) begin
                errors++;
                $display("FAIL cont_cadence cycle %0d: got valid=%0b ota_en=%0b, required %0b 1",
                         k, res_if.res_valid, ota_en, ((k % 2) == 0));
            end
        end
        res_if.res_ready = 1'b0;
        ena = 1'b0;
        step(1);
        checks++;
        if (res_if.res_valid !== 1'b0 || ota_en !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL cont_exit: got valid=%0b ota_en=%0b busy=%0b state=%0d, required 0 0 0 0",
                     res_if.res_valid, ota_en, busy, dbg_state);
        end
        ena = 1'b1;
        res_if.res_ready = 1'b1;
        step(1);
    endtask

    task automatic test_abort();
        int lat;
        int n;
        cmp_in = 1'b1; cfg_settle = 8'd2; cfg_nsamp = 4'd7; cfg_cont = 1'b0;
        res_if.res_ready = 1'b1;
        step(3);
        start = 1'b1;
        step(1);
        start = 1'b0;
        n = 0;
        while (dbg_state !== SAMPLE && n < 50) begin
            step(1);
            n++;
        end
        checks++;
        if (dbg_state !== SAMPLE) begin
            errors++;
            $display("FAIL abort_reach_sample: got state=%0d, required %0d", dbg_state, SAMPLE);
        end
        step(2);
        ena = 1'b0;
        step(1);
        checks++;
        if (dbg_state !== IDLE || ota_en !== 1'b0 || busy !== 1'b0 || res_if.res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got state=%0d ota_en=%0b busy=%0b valid=%0b, required 0 0 0 0",
                     dbg_state, ota_en, busy, res_if.res_valid);
        end
        // start while disabled must not begin a conversion
        start = 1'b1;
        step(1);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL abort_start_while_disabled: got busy=%0b state=%0d, required 0 0", busy, dbg_state);
        end
        step(15);
        ena = 1'b1;
        cmp_in = 1'b0; cfg_settle = 8'd1; cfg_nsamp = 4'd2;
        step(3);
        push_exp(1'b0, 0);
        start_and_wait(lat);
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL abort_fresh_latency: got %0d, required 6", lat);
        end
        step(1);
    endtask

    task automatic test_async_reset();
        cmp_in = 1'b1; cfg_settle = 8'd4; cfg_nsamp = 4'd5; cfg_cont = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        exp_conv = 0;
        exp_hi   = 0;
        checks++;
        if (ota_en !== 1'b0 || busy !== 1'b0 || res_if.res_valid !== 1'b0 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL async_reset: got ota_en=%0b busy=%0b valid=%0b state=%0d, required 0 0 0 0",
                     ota_en, busy, res_if.res_valid, dbg_state);
        end
        step(1);
        rst_n = 1'b1;
        step(2);
        checks++;
        if (stat_conv !== '0 || stat_hi !== '0) begin
            errors++;
            $display("FAIL async_reset_stats: got conv=%0d hi=%0d, required 0 0", stat_conv, stat_hi);
        end
    endtask

    task automatic test_random();
        int lat;
        int s;
        int nn;
        logic b;
        res_if.res_ready = 1'b1;
        cfg_cont = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s  = $urandom_range(0, 20);
            nn = $urandom_range(1, 16);
            b  = 1'($urandom_range(0, 1));
            cfg_settle = SETTLE_W'(s);
            cfg_nsamp  = NSAMP_W'(nn - 1);
            cmp_in     = b;
            step(3);
            push_exp(b, b ? nn : 0);
            start_and_wait(lat);
            checks++;
            if (lat !== 2 + s + nn) begin
                errors++;
                $display("FAIL random_latency s=%0d n=%0d: got %0d, required %0d", s, nn, lat, 2 + s + nn);
            end
            step(1);
        end
    endtask

    task automatic test_stats();
        int lat;
        logic [2:0] pat;
        pat = 3'b101;
        cfg_settle = 8'd1; cfg_nsamp = 4'd2; cfg_cont = 1'b0;
        res_if.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmp_in = pat[i];
            step(3);
            push_exp(pat[i], pat[i] ? 3 : 0);
            start_and_wait(lat);
            step(1);
        end
        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d outstanding, required 0", exp_q.size());
        end
`ifdef DOTA_STATS_EN
        checks++;
        if (stat_conv !== STAT_W'(exp_conv) || stat_hi !== STAT_W'(exp_hi)) begin
            errors++;
            $display("FAIL stats: got conv=%0d hi=%0d, required %0d %0d", stat_conv, stat_hi, exp_conv, exp_hi);
        end
`else
        checks++;
        if (stat_conv !== '0 || stat_hi !== '0) begin
            errors++;
            $display("FAIL stats_disabled: got conv=%0d hi=%0d, required 0 0", stat_conv, stat_hi);
        end
`endif
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_continuous();
        test_abort();
        test_random();
        test_async_reset();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
